// File: rtl/axis_reg_stage.sv
// axis_reg_stage: AXI4-Stream register stage, slice (SKID=0) or two-entry skid buffer (SKID=1).
// Latency: 1 cycle, full throughput in both modes; invalidate flushes all held beats.
// Backpressure: slice s_tready is combinational from m_tready; skid s_tready is registered.
// Optional sideband: define AXIS_REG_STAGE_TLAST_EN to add s_tlast/m_tlast carried with tdata.
//
// Ports: clk, rst (async active-high), s_tvalid/s_tready/s_tdata (upstream),
//        m_tvalid/m_tready/m_tdata (downstream), invalidate (flush stored beats),
//        s_tlast/m_tlast (only with AXIS_REG_STAGE_TLAST_EN).
module axis_reg_stage #(
  parameter int TDATA_WIDTH = 32,
  parameter int SKID        = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
`ifdef AXIS_REG_STAGE_TLAST_EN
  input  logic                   s_tlast,
  output logic                   m_tlast,
`endif
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  input  logic                   invalidate
);

  // Elaboration-time parameter sanity check.
  if (TDATA_WIDTH < 1 || (SKID != 0 && SKID != 1)) begin : g_bad_param
    $fatal(1, "axis_reg_stage: TDATA_WIDTH must be >= 1 and SKID must be 0 or 1");
  end

  localparam bit USE_SKID = (SKID == 1);

  // Payload is tdata plus, optionally, tlast in the top bit.
`ifdef AXIS_REG_STAGE_TLAST_EN
  localparam int PW = TDATA_WIDTH + 1;
`else
  localparam int PW = TDATA_WIDTH;
`endif

  logic [PW-1:0] s_pay;
  logic          main_valid_q, main_valid_d;
  logic [PW-1:0] main_data_q,  main_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] skid_data_q,  skid_data_d;
  logic          in_hs;
  logic          out_hs;

`ifdef AXIS_REG_STAGE_TLAST_EN
  assign s_pay   = {s_tlast, s_tdata};
  assign m_tlast = main_data_q[PW-1];
`else
  assign s_pay   = s_tdata;
`endif
  assign m_tdata = main_data_q[TDATA_WIDTH-1:0];

  // invalidate masks both sides so no beat moves during a flush cycle.
  always_comb begin
    if (USE_SKID) begin
      // Registered ready: depends only on skid occupancy (plus reset/flush).
      s_tready = !skid_valid_q && !rst && !invalidate;
    end else begin
      s_tready = (!main_valid_q || m_tready) && !invalidate;
    end
  end

  assign m_tvalid = main_valid_q && !invalidate;
  assign in_hs    = s_tvalid && s_tready;
  assign out_hs   = m_tvalid && m_tready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (invalidate) begin
      // Flush clears only the valid flags; data registers keep their contents.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_hs) begin
        if (skid_valid_q) begin
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      // An accepted beat implies skid is empty (s_tready=!skid_valid in skid
      // mode; skid never fills in slice mode because accepting into a full
      // main always coincides with a drain).
      if (in_hs) begin
        if (!main_valid_q || out_hs) begin
          main_data_d  = s_pay;
          main_valid_d = 1'b1;
        end else begin
          skid_data_d  = s_pay;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_axis_reg_stage.sv
// Bench for axis_reg_stage: drives a slice instance and a skid instance from
// the same inputs and checks each against a bounded-capacity queue model.
module tb_axis_reg_stage;

  logic       clk;
  logic       rst;
  logic       s_tvalid;
  logic [7:0] s_tdata;
  logic       s_tlast;
  logic       m_tready;
  logic       invalidate;
  logic [1:0] srdy;
  logic [1:0] mvld;
  logic [7:0] mdat0, mdat1;
`ifdef AXIS_REG_STAGE_TLAST_EN
  logic       mlast0, mlast1;
`endif

  int total = 0;
  int bad   = 0;

  // Model: each stage is a FIFO of {tlast,tdata}; capacity 1 (slice) or 2 (skid).
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  axis_reg_stage #(.TDATA_WIDTH(8), .SKID(0)) u_slice (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(srdy[0]), .s_tdata(s_tdata),
`ifdef AXIS_REG_STAGE_TLAST_EN
    .s_tlast(s_tlast), .m_tlast(mlast0),
`endif
    .m_tvalid(mvld[0]), .m_tready(m_tready), .m_tdata(mdat0),
    .invalidate(invalidate)
  );

  axis_reg_stage #(.TDATA_WIDTH(8), .SKID(1)) u_skid (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(srdy[1]), .s_tdata(s_tdata),
`ifdef AXIS_REG_STAGE_TLAST_EN
    .s_tlast(s_tlast), .m_tlast(mlast1),
`endif
    .m_tvalid(mvld[1]), .m_tready(m_tready), .m_tdata(mdat1),
    .invalidate(invalidate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs vs model, clock, update model.
  task automatic step(input logic sv, input logic [7:0] sd, input logic sl,
                      input logic mr, input logic inv);
    int n0, n1;
    logic er0, er1, ev0, ev1;
    logic [8:0] pay, f;
    s_tvalid = sv; s_tdata = sd; s_tlast = sl; m_tready = mr; invalidate = inv;
    #1;
    n0  = q0.size();
    n1  = q1.size();
    er0 = !inv && (n0 == 0 || mr);
    er1 = !inv && (n1 < 2);
    ev0 = !inv && (n0 > 0);
    ev1 = !inv && (n1 > 0);
    pay = {sl, sd};
    chk("slice_s_tready", 32'(srdy[0]), 32'(er0));
    chk("skid_s_tready",  32'(srdy[1]), 32'(er1));
    chk("slice_m_tvalid", 32'(mvld[0]), 32'(ev0));
    chk("skid_m_tvalid",  32'(mvld[1]), 32'(ev1));
    if (ev0) begin
      f = q0[0];
      chk("slice_m_tdata", 32'(mdat0), 32'(f[7:0]));
`ifdef AXIS_REG_STAGE_TLAST_EN
      chk("slice_m_tlast", 32'(mlast0), 32'(f[8]));
`endif
    end
    if (ev1) begin
      f = q1[0];
      chk("skid_m_tdata", 32'(mdat1), 32'(f[7:0]));
`ifdef AXIS_REG_STAGE_TLAST_EN
      chk("skid_m_tlast", 32'(mlast1), 32'(f[8]));
`endif
    end
    // Skid-mode ready must not follow m_tready within the cycle.
    m_tready = !mr;
    #1;
    chk("skid_s_tready_vs_m_tready", 32'(srdy[1]), 32'(er1));
    m_tready = mr;
    #1;
    @(posedge clk);
    if (inv) begin
      q0.delete();
      q1.delete();
    end else begin
      if (ev0 && mr) void'(q0.pop_front());
      if (sv && er0) q0.push_back(pay);
      if (ev1 && mr) void'(q1.pop_front());
      if (sv && er1) q1.push_back(pay);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0;
    m_tready = 1'b0; invalidate = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_slice_m_tvalid", 32'(mvld[0]), 32'd0);
    chk("rst_skid_m_tvalid",  32'(mvld[1]), 32'd0);
    chk("rst_skid_s_tready",  32'(srdy[1]), 32'd0);
    chk("rst_slice_m_tdata",  32'(mdat0), 32'd0);
    chk("rst_skid_m_tdata",   32'(mdat1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_slice_m_tdata", 32'(mdat0), 32'd0);
    chk("idle_skid_m_tdata",  32'(mdat1), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Back-to-back stream, no bubble expected
    step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Fill under backpressure, then drain
    step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    chk("skid_full_s_tready", 32'(srdy[1]), 32'd0);
    step(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Invalidate a full stage while a new beat is offered
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // tlast sideband alignment
    step(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 2500; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset mid-transfer
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_slice_m_tvalid", 32'(mvld[0]), 32'd0);
    chk("async_rst_skid_m_tvalid",  32'(mvld[1]), 32'd0);
    chk("async_rst_skid_s_tready",  32'(srdy[1]), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
